// File: rtl/dactest_sweep_ctrl.sv
// Linear frequency-sweep sequencer for the DAC test: steps an NCO increment per step,
// muting the sinus output during each settle window and enabling it during the dwell window.
module dactest_sweep_ctrl #(
  parameter int AccWidth   = 51,
  parameter int PhaseBits  = 5,
  parameter int CountWidth = 24,
  parameter int StepWidth  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [AccWidth-1:0]   cfg_f_start,
  input  logic [AccWidth-1:0]   cfg_f_step,
  input  logic [StepWidth-1:0]  cfg_n_steps,
  input  logic [CountWidth-1:0] cfg_settle,
  input  logic [CountWidth-1:0] cfg_dwell,
  input  logic [7:0]            cfg_amplitude,
  output logic [PhaseBits-1:0]  phase,
  output logic [7:0]            amplitude,
  output logic [AccWidth-1:0]   phase_inc,
  output logic [StepWidth-1:0]  step_index,
  output logic                  step_strobe,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DWELL,
    ST_DONE
  } state_t;

  state_t                state_q;
  logic [AccWidth-1:0]   f_step_q;
  logic [StepWidth-1:0]  last_step_q;
  logic                  settle_zero_q;
  logic [CountWidth-1:0] settle_last_q;
  logic [CountWidth-1:0] dwell_last_q;
  logic [7:0]            amp_cfg_q;
  logic [CountWidth-1:0] cnt_q;
  logic [AccWidth-1:0]   acc_q;
  logic [AccWidth-1:0]   acc_d;
  logic [AccWidth-1:0]   phase_inc_q;
  logic [StepWidth-1:0]  step_index_q;
  logic [7:0]            amp_q;
  logic                  strobe_q;
  logic                  busy_q;
  logic                  done_q;

  assign acc_d = acc_q + phase_inc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      f_step_q      <= '0;
      last_step_q   <= '0;
      settle_zero_q <= 1'b0;
      settle_last_q <= '0;
      dwell_last_q  <= '0;
      amp_cfg_q     <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      phase_inc_q   <= '0;
      step_index_q  <= '0;
      amp_q         <= '0;
      strobe_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          acc_q  <= '0;
          amp_q  <= '0;
          busy_q <= 1'b0;
          if (start && !stop) begin
            // Shadow copies freeze the sweep against cfg changes while running.
            f_step_q      <= cfg_f_step;
            last_step_q   <= (cfg_n_steps == '0) ? '0 : cfg_n_steps - StepWidth'(1);
            settle_zero_q <= (cfg_settle == '0);
            settle_last_q <= cfg_settle - CountWidth'(1);
            dwell_last_q  <= (cfg_dwell == '0) ? '0 : cfg_dwell - CountWidth'(1);
            amp_cfg_q     <= cfg_amplitude;
            phase_inc_q   <= cfg_f_start;
            step_index_q  <= '0;
            strobe_q      <= 1'b1;
            busy_q        <= 1'b1;
            cnt_q         <= '0;
            if (cfg_settle == '0) begin
              state_q <= ST_DWELL;
              amp_q   <= cfg_amplitude;
            end else begin
              state_q <= ST_SETTLE;
            end
          end
        end

        ST_SETTLE, ST_DWELL: begin
          if (stop) begin
            state_q <= ST_IDLE;
            amp_q   <= '0;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            if (state_q == ST_SETTLE) begin
              if (cnt_q == settle_last_q) begin
                state_q <= ST_DWELL;
                cnt_q   <= '0;
                amp_q   <= amp_cfg_q;
              end else begin
                cnt_q <= cnt_q + CountWidth'(1);
              end
            end else if (cnt_q == dwell_last_q) begin
              cnt_q <= '0;
              if (step_index_q == last_step_q) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                amp_q   <= '0;
                done_q  <= 1'b1;
              end else begin
                step_index_q <= step_index_q + StepWidth'(1);
                phase_inc_q  <= phase_inc_q + f_step_q;
                strobe_q     <= 1'b1;
                // With no settle window the next step starts straight in DWELL.
                if (!settle_zero_q) begin
                  state_q <= ST_SETTLE;
                  amp_q   <= '0;
                end
              end
            end else begin
              cnt_q <= cnt_q + CountWidth'(1);
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          acc_q   <= '0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign phase       = acc_q[AccWidth-1 -: PhaseBits];
  assign amplitude   = amp_q;
  assign phase_inc   = phase_inc_q;
  assign step_index  = step_index_q;
  assign step_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/dactest_sweep_ctrl.md
Name: dactest_sweep_ctrl

Overview:
- Sequences the DAC frequency test. Steps a phase-accumulator NCO through a programmable linear frequency sweep and drives the phase and amplitude inputs of the existing sinus lookup block.
- Each step has a muted settle window followed by a dwell window at full amplitude.
- Sits between the test top level (start/config from switches or UART) and the sinus/DAC output path.

Parameters:
- AccWidth, 51, phase accumulator and increment width
- PhaseBits, 5, accumulator MSBs presented as sinus phase
- CountWidth, 24, width of dwell and settle counters
- StepWidth, 8, width of step count/index

Ports:
- clk  in  1  system clock (NCO sample clock)
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a sweep when idle
- stop  in  1  one-cycle pulse; aborts a running sweep
- cfg_f_start  in  AccWidth  increment of step 0
- cfg_f_step  in  AccWidth  increment added per step (unsigned, wraps)
- cfg_n_steps  in  StepWidth  number of steps; 0 treated as 1
- cfg_settle  in  CountWidth  muted cycles per step
- cfg_dwell  in  CountWidth  audible cycles per step; 0 treated as 1
- cfg_amplitude  in  8  amplitude during dwell
- phase  out  PhaseBits  accumulator[AccWidth-1 -: PhaseBits]
- amplitude  out  8  to sinus amplitude input
- phase_inc  out  AccWidth  current increment (debug/UART readback)
- step_index  out  StepWidth  current step number
- step_strobe  out  1  one-cycle pulse on entry to each step
- busy  out  1  high in SETTLE or DWELL
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: state IDLE, accumulator=0, phase_inc=0, amplitude=0, step_index=0, step_strobe=0, busy=0, done=0, counters=0. All outputs are registered.
- States: IDLE, SETTLE, DWELL, DONE.
- IDLE:
  - Accumulator held at 0; amplitude=0.
  - start=1 latches all cfg_* into shadow registers.
  - Next cycle: SETTLE, phase_inc=cfg_f_start, step_index=0, step_strobe=1, busy=1, counter=0.
  - cfg_* changes during a sweep have no effect.
- Accumulator: acc <= acc + phase_inc every cycle while busy, modulo 2^AccWidth. It is not reset between steps, so phase stays continuous. It starts accumulating on the first SETTLE cycle.
- SETTLE:
  - amplitude=0.
  - Lasts exactly settle cycles. settle=0 skips SETTLE: step entry goes directly to DWELL, with step_strobe still asserted.
  - Then enter DWELL with counter=0.
- DWELL:
  - amplitude=shadow amplitude.
  - Lasts exactly max(dwell,1) cycles.
  - At end, if step_index == max(n_steps,1)-1: enter DONE. Otherwise step_index+1, phase_inc <= phase_inc + f_step (wrap), step_strobe=1, enter SETTLE.
- DONE:
  - One cycle long: done=1, busy=0, amplitude=0.
  - Then IDLE, accumulator cleared.
- stop:
  - In SETTLE or DWELL: next cycle IDLE, amplitude=0, busy=0, accumulator cleared, no done pulse.
  - stop and start in the same cycle while IDLE: stop wins, and the sweep does not start.
  - stop in IDLE or DONE is ignored.
- start while busy or in DONE is ignored.
- Asynchronous rst mid-sweep returns immediately to reset values. No done pulse is issued.
- Total sweep length from start pulse to done pulse = 1 + N*(settle + max(dwell,1)) cycles, where N = max(n_steps,1).

Test Plan:
- Reset/idle (AccWidth=16): rst asserted mid-sweep -> all outputs 0 asynchronously. After release, busy=0 and phase=0 stay constant for 100 cycles.
- Basic sweep (f_start=0x0800, f_step=0x0400, n_steps=3, settle=2, dwell=4, amp=12):
  - step_strobe at cycles 1, 7, 13; phase_inc = 0x0800, 0x0C00, 0x1000.
  - amplitude=0 for 2 cycles then 12 for 4 cycles in each step.
  - done at cycle 19.
- Phase continuity: across each step boundary, acc(n+1) = acc(n) + phase_inc(n+1) with no reset. Compare against a reference model for the whole sweep.
- Edge configs:
  - n_steps=0, dwell=0, settle=0 -> single step, one DWELL cycle, done at cycle 2.
  - f_step=0xFFFF (AccWidth=16) -> increment decrements by 1 per step (wrap).
- Abort: stop during step 1 DWELL -> next cycle busy=0, amplitude=0, phase=0, no done pulse. A new start afterwards sweeps from step 0.
- Ignored inputs:
  - start during DWELL -> no change.
  - Changing cfg_f_step mid-sweep -> increments unaffected.
  - start+stop together while IDLE -> stays IDLE.
